player_executor: RTL
====================

Name: player_executor

Overview:
- Executes the 16-bit player instruction word issued by the game state machine during the DODGE page.
- Owns the player's soul position and HP.
- Reports death and damage-window status back to the state machine (`isDeath`, `isDmgComplete`).
- Sits directly downstream of the state machine; position feeds the renderer and collision logic.

Parameters:
- X_MIN, 8'd10, left arena bound (inclusive)
- X_MAX, 8'd150, right arena bound (inclusive)
- Y_MIN, 8'd10, top arena bound (inclusive)
- Y_MAX, 8'd110, bottom arena bound (inclusive)
- START_X, 8'd80, X position after reset/restart
- START_Y, 8'd60, Y position after reset/restart
- MAX_HP, 8'd100, HP ceiling and initial HP
- STEP, 8'd2, pixels moved per accepted step
- MOVE_DIV, 20'd250000, clk cycles between movement steps
- IFRAME_CYCLES, 24'd5000000, cooldown after an accepted HPY/DPY

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- playerInstruction, input, 16, [15:12] opcode, [11:4] operand, [3:0] unused (zero)
- isMove, input, 1, movement-valid qualifier from the state machine
- restart, input, 1, single-cycle pulse: new game (state machine leaving MENU)
- playerX, output, 8, current X
- playerY, output, 8, current Y
- playerHP, output, 8, current HP, 0..MAX_HP
- isDeath, output, 1, high while the player is dead
- isDmgComplete, output, 1, high when HPY/DPY will be accepted

Behaviour:
- Reset (async) and restart (sync, priority over everything):
  - playerX=START_X, playerY=START_Y, playerHP=MAX_HP.
  - isDeath=0, isDmgComplete=1.
  - FSM=READY; divider and cooldown counters cleared.
- Opcodes: HPY=4'h1, DPY=4'h2, MOV=4'h5. All others, including 0, are NOPs.
- FSM states: READY, COOLDOWN, DEAD.
- READY:
  - DPY with operand d>0: HP_next = (HP>d) ? HP−d : 0. If HP_next==0, go to DEAD; else go to COOLDOWN.
  - DPY with d==0: ignored, stay in READY.
  - HPY with operand h: HP_next = min(HP+h, MAX_HP), computed in 9 bits. Go to COOLDOWN.
  - HP update is registered on the same clk edge the opcode is sampled (1-cycle latency).
- COOLDOWN:
  - isDmgComplete=0.
  - HPY/DPY ignored. The instruction register upstream holds its value, so this prevents repeated application.
  - Counter runs 0..IFRAME_CYCLES−1, then returns to READY; isDmgComplete=1 on the following cycle.
- DEAD:
  - isDeath=1 (registered, asserted the cycle after HP reaches 0).
  - isDmgComplete=0.
  - All opcodes ignored; exits only via reset or restart.
- Movement (READY or COOLDOWN only):
  - Free-running divider emits stepTick for one cycle every MOVE_DIV clks.
  - On stepTick with isMove=1 and opcode==MOV, apply operand[1:0]: 0=up (Y−STEP), 1=right (X+STEP), 2=down (Y+STEP), 3=left (X−STEP). Operand[7:2] is ignored.
  - Clamp to [X_MIN,X_MAX] / [Y_MIN,Y_MAX]. Compute in 9 bits so there is no wrap at 0 or 255.
  - MOV without stepTick does nothing.
  - isMove=1 with a non-MOV opcode does nothing.
- Concurrency: one opcode per cycle. Movement and HP never conflict because they come from distinct opcodes.
- Outputs are all registered; no combinational input-to-output path.

Decomposition:
- Shared package `game_pkg`:
  - opcode constants HPY/DPY/IDG/SDG/MOV/SHP
  - direction constants UP/RIGHT/DOWN/LEFT
  - key and page enums
  - HP width
  - state machine and other game blocks import the same values.
- One sub-module `step_tick`:
  - parameterised divider producing a 1-cycle enable.
  - async active-high reset; synchronous clear input driven by restart.

Test Plan:
- Reset mid-cooldown, after a DPY 8'd30: next cycle X=80, Y=60, HP=100, isDmgComplete=1, isDeath=0.
- DPY 8'd30 held for 3×IFRAME_CYCLES (bench IFRAME_CYCLES=16):
  - HP 100→70 once.
  - isDmgComplete low exactly 16 cycles.
  - HP→40 once after it reasserts.
- HP=40, HPY 8'd10 → HP=50. HP=95, HPY 8'd10 → HP=100 (saturates). Each is followed by cooldown.
- HP=20, DPY 8'd25 → HP=0, isDeath=1 the next cycle. Further HPY/MOV/DPY cause no change. A restart pulse gives HP=100, X=80, Y=60, isDeath=0.
- Movement (MOVE_DIV=4), MOV/LEFT with isMove=1 from X=14:
  - X=12 at the first tick, 10 at the second, stays 10 thereafter.
  - MOV/DOWN from Y=108: 110 then stays 110.
  - isMove=0: no motion.
- MOV/RIGHT during COOLDOWN: X advances; DPY issued in the same window is ignored.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, enums and small arithmetic helpers used by the game
// state machine and its downstream executors.
package game_pkg;

    localparam int HP_W = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_HPY = 4'h1;
    localparam logic [3:0] OP_DPY = 4'h2;
    localparam logic [3:0] OP_IDG = 4'h3;
    localparam logic [3:0] OP_SDG = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_SHP = 4'h6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        KEY_NONE, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_CONFIRM
    } key_e;

    typedef enum logic [1:0] {
        PAGE_MENU, PAGE_DIALOG, PAGE_DODGE, PAGE_GAMEOVER
    } page_e;

    typedef enum logic [1:0] {
        PE_READY, PE_COOLDOWN, PE_DEAD
    } pe_state_e;

    // Widened to 9 bits so positions near 0 or 255 never wrap before clamping.
    function automatic logic [7:0] step_dec(input logic [7:0] pos,
                                            input logic [7:0] step,
                                            input logic [7:0] lo);
        logic [8:0] lim;
        lim = {1'b0, lo} + {1'b0, step};
        return ({1'b0, pos} < lim) ? lo : pos - step;
    endfunction

    function automatic logic [7:0] step_inc(input logic [7:0] pos,
                                            input logic [7:0] step,
                                            input logic [7:0] hi);
        logic [8:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        return (sum > {1'b0, hi}) ? hi : sum[7:0];
    endfunction

endpackage

// File: rtl/player_executor_if.sv
// Instruction/status bundle between the game state machine (master) and the
// player executor (slave).
interface player_executor_if;
    logic [15:0] playerInstruction;
    logic        isMove;
    logic        restart;
    logic [7:0]  playerX;
    logic [7:0]  playerY;
    logic [7:0]  playerHP;
    logic        isDeath;
    logic        isDmgComplete;

    modport master (
        output playerInstruction, isMove, restart,
        input  playerX, playerY, playerHP, isDeath, isDmgComplete
    );

    modport slave (
        input  playerInstruction, isMove, restart,
        output playerX, playerY, playerHP, isDeath, isDmgComplete
    );
endinterface

// File: rtl/player_executor_step_tick.sv
// Free-running down-counter divider: tick_o is high for one cycle every DIV clocks.
module step_tick #(
    parameter int         W   = 20,
    parameter logic [W-1:0] DIV = 20'd250000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);
    localparam logic [W-1:0] RELOAD = DIV - 1'b1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/player_executor.sv
// Applies DODGE-page player instructions: owns soul position and HP, and
// reports death / damage-window status back to the game state machine.
module player_executor
    import game_pkg::*;
#(
    parameter logic [7:0]  X_MIN         = 8'd10,
    parameter logic [7:0]  X_MAX         = 8'd150,
    parameter logic [7:0]  Y_MIN         = 8'd10,
    parameter logic [7:0]  Y_MAX         = 8'd110,
    parameter logic [7:0]  START_X       = 8'd80,
    parameter logic [7:0]  START_Y       = 8'd60,
    parameter logic [7:0]  MAX_HP        = 8'd100,
    parameter logic [7:0]  STEP          = 8'd2,
    parameter logic [19:0] MOVE_DIV      = 20'd250000,
    parameter logic [23:0] IFRAME_CYCLES = 24'd5000000
) (
    input  logic              clk,
    input  logic              reset,
    player_executor_if.slave  pif
);
    // state    | meaning
    // READY    | HPY/DPY accepted, movement allowed
    // COOLDOWN | i-frames after an HP change; HPY/DPY ignored, movement allowed
    // DEAD     | HP hit 0; everything ignored until reset/restart

    pe_state_e     state_q, state_d;
    logic [7:0]    x_q, x_d, y_q, y_d, hp_q, hp_d;
    logic          death_q, death_d, dmg_q, dmg_d;
    logic [23:0]   cool_q, cool_d;
    logic [3:0]    opcode;
    logic [7:0]    operand;
    logic [8:0]    hp_sum;
    logic          step_tick_w;
    logic          unused_bits;

    assign opcode      = pif.playerInstruction[15:12];
    assign operand     = pif.playerInstruction[11:4];
    assign unused_bits = ^pif.playerInstruction[3:0];
    assign hp_sum      = {1'b0, hp_q} + {1'b0, operand};

    step_tick #(.W(20), .DIV(MOVE_DIV)) u_step_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (pif.restart),
        .tick_o (step_tick_w)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hp_d    = hp_q;
        cool_d  = cool_q;

        case (state_q)
            PE_READY: begin
                if (opcode == OP_DPY && operand != 8'd0) begin
                    hp_d = (hp_q > operand) ? hp_q - operand : 8'd0;
                    if (hp_d == 8'd0) begin
                        state_d = PE_DEAD;
                    end else begin
                        state_d = PE_COOLDOWN;
                        cool_d  = IFRAME_CYCLES - 24'd1;
                    end
                end else if (opcode == OP_HPY) begin
                    hp_d    = (hp_sum > {1'b0, MAX_HP}) ? MAX_HP : hp_sum[7:0];
                    state_d = PE_COOLDOWN;
                    cool_d  = IFRAME_CYCLES - 24'd1;
                end
            end
            PE_COOLDOWN: begin
                if (cool_q == 24'd0) begin
                    state_d = PE_READY;
                end else begin
                    cool_d = cool_q - 24'd1;
                end
            end
            PE_DEAD: begin
            end
            default: state_d = PE_READY;
        endcase

        if (state_q != PE_DEAD && step_tick_w && pif.isMove && opcode == OP_MOV) begin
            case (operand[1:0])
                DIR_UP:    y_d = step_dec(y_q, STEP, Y_MIN);
                DIR_RIGHT: x_d = step_inc(x_q, STEP, X_MAX);
                DIR_DOWN:  y_d = step_inc(y_q, STEP, Y_MAX);
                default:   x_d = step_dec(x_q, STEP, X_MIN);
            endcase
        end

        // isDeath trails the DEAD state by one cycle; the window flag tracks it directly.
        death_d = (state_q == PE_DEAD);
        dmg_d   = (state_d == PE_READY);

        if (pif.restart) begin
            state_d = PE_READY;
            x_d     = START_X;
            y_d     = START_Y;
            hp_d    = MAX_HP;
            cool_d  = 24'd0;
            death_d = 1'b0;
            dmg_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PE_READY;
            x_q     <= START_X;
            y_q     <= START_Y;
            hp_q    <= MAX_HP;
            cool_q  <= 24'd0;
            death_q <= 1'b0;
            dmg_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hp_q    <= hp_d;
            cool_q  <= cool_d;
            death_q <= death_d;
            dmg_q   <= dmg_d;
        end
    end

    assign pif.playerX       = x_q;
    assign pif.playerY       = y_q;
    assign pif.playerHP      = hp_q;
    assign pif.isDeath       = death_q;
    assign pif.isDmgComplete = dmg_q;
endmodule
